// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 2-read/1-write integer register file.
// The write-first read path is compiled in when REGFILE_WRITE_BYPASS_EN is defined.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  // True when a read index hits the index being written this cycle; index 0 never hits.
  function automatic logic wr_hit(input logic we, input reg_idx_t waddr, input reg_idx_t raddr);
    return we && (waddr != reg_idx_t'(ZERO_REG)) && (raddr == waddr);
  endfunction

endpackage

// File: rtl/regfile_2r1w_reg_word.sv
// One register of the file: rising-edge load when en is high, asynchronous clear on clr.
module reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] word_q;
  logic [W-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (en) word_d = d;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) word_q <= '0;
    else     word_q <= word_d;
  end

  assign q = word_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Architectural register file: one synchronous write port, two combinational read ports, r0 == 0.
// Define REGFILE_WRITE_BYPASS_EN for write-first reads of the index being written.
module regfile_2r1w #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  import regfile_pkg::*;

  logic [DATA_W-1:0] reg_file [NUM_REGS];

  // Register 0 is a constant, never a flop.
  assign reg_file[ZERO_REG] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_word
      logic wr_en;
      assign wr_en = we && (waddr == ADDR_W'(gi));

      reg_word #(.W(DATA_W)) u_word (
        .clk (clk),
        .clr (clr),
        .en  (wr_en),
        .d   (wdata),
        .q   (reg_file[gi])
      );
    end
  endgenerate

  always_comb begin
    rdata_a = (raddr_a == ADDR_W'(ZERO_REG)) ? '0 : reg_file[raddr_a];
    rdata_b = (raddr_b == ADDR_W'(ZERO_REG)) ? '0 : reg_file[raddr_b];
`ifdef REGFILE_WRITE_BYPASS_EN
    // Forwarding is suppressed during clr so the file still reads all-zero while cleared.
    if (!clr && (we && (waddr != ADDR_W'(ZERO_REG)) && (raddr_a == waddr))) rdata_a = wdata;
    if (!clr && (we && (waddr != ADDR_W'(ZERO_REG)) && (raddr_b == waddr))) rdata_b = wdata;
`endif
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Architectural integer register file for the 5-stage processor.
- One synchronous write port, written by the writeback stage.
- Two asynchronous read ports, read by the decode stage.
- Register 0 is hardwired to zero. All storage clears asynchronously on clr.

Parameters:
- DATA_W, 32, width of each register in bits.
- NUM_REGS, 32, number of architectural registers; must be a power of two.
- ADDR_W, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  clock; all writes occur on its rising edge.
- clr  input  1  asynchronous active-high reset; clears every register to 0.
- we  input  1  write enable from writeback.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- raddr_a  input  ADDR_W  read port A index (rs).
- raddr_b  input  ADDR_W  read port B index (rt).
- rdata_a  output  DATA_W  read port A data.
- rdata_b  output  DATA_W  read port B data.

Behaviour:
- Reset:
  - clk is a single clock; clr is asynchronous, active-high.
  - While clr=1, all registers are 0, so rdata_a = rdata_b = 0, regardless of clk, we or addresses.
  - Deassertion of clr is synchronised externally; the block adds no synchroniser.
- Write:
  - On posedge clk with clr=0, we=1 and waddr!=0: reg[waddr] <= wdata.
  - we=0: no register changes.
  - waddr=0 with we=1: the write is discarded and reg[0] stays 0.
- Read:
  - Combinational: rdata_x = (raddr_x==0) ? 0 : reg[raddr_x].
  - Zero-cycle latency from address change.
- Read-during-write, same index, same cycle, base build:
  - rdata shows the old value until the edge, then the new value.
- Simultaneous clr and write edge: clr wins; the register stays 0.
- clr asserted mid-operation: contents are lost immediately. Writes resume on the first edge after clr falls.
- Both read ports may address the same register; both return identical data.
- Out-of-range index is impossible because NUM_REGS = 2^ADDR_W, so there is no wrap handling.
- Each non-zero register uses its own enable, decoded as we & (waddr==i). At most one register updates per edge.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - When we=1, waddr!=0 and raddr_x==waddr in the same cycle, rdata_x = wdata combinationally.
  - This is write-first behaviour, so decode sees writeback data without a separate WB->D bypass path.
  - Index 0 is never bypassed.
- Undefined:
  - Read-old behaviour as described in Behaviour.
  - The pipeline must supply its own bypass or stall.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W and ADDR_W constants.
  - NUM_REGS.
  - ZERO_REG index constant (0).
  - A reg_idx_t typedef (ADDR_W bits) and a word_t typedef (DATA_W bits).
- Sub-module reg_word: one DATA_W-bit register with ports clk, clr, en, d, q.
  - Posedge write when en=1; asynchronous clear to 0; initial value 0.
  - Instantiate it NUM_REGS-1 times with a generate loop; reg[0] is a constant zero, not a flop.

Test Plan:
- Reset: pulse clr mid-cycle after writing reg[5]=0xDEADBEEF -> rdata_a with raddr_a=5 is 0 immediately, before any clk edge.
- Write/read: we=1, waddr=7, wdata=0x12345678, then one edge -> raddr_a=7 gives 0x12345678; raddr_b=8 gives 0.
- Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, then an edge -> raddr_a=0 and raddr_b=0 both read 0.
- Enable low: preload reg[3]=0xA5A5A5A5; we=0, waddr=3, wdata=0x1 for 4 edges -> reg[3] still reads 0xA5A5A5A5.
- Same-cycle read/write: reg[9]=0x11; drive we=1, waddr=9, wdata=0x22, raddr_a=9 before the edge:
  - Bypass undefined -> rdata_a=0x11 before the edge, 0x22 after.
  - REGFILE_WRITE_BYPASS_EN defined -> rdata_a=0x22 before the edge.
- Sweep: write reg[i]=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) on A/B -> every value matches; index 0 reads 0; clr at the end zeroes all 31.
